int_ctrl: RTL and testbench

Machine-level interrupt controller feeding the CSR register file. Contains a CLINT-style 64-bit `mtime`/`mtimecmp` timer, a software-interrupt bit, and level-sensitive external interrupt capture. Composes the `mip` image, arbitrates enabled pending interrupts by priority, and issues a single-cycle take request (`int_action`, `int_code`, `hw_int`) at an instruction boundary. Holds off further requests until `mret`.

---
 rtl/int_ctrl_pkg.sv | 35 +++
 rtl/clint_mtime.sv | 55 +++++
 rtl/int_ctrl.sv | 158 +++++++++++++++
 tb/tb_int_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the machine-level interrupt controller: bus map, mip bit
// positions, cause codes and FSM states.
package int_ctrl_pkg;

    localparam logic [2:0] AddrMtimeLo    = 3'd0;
    localparam logic [2:0] AddrMtimeHi    = 3'd1;
    localparam logic [2:0] AddrMtimecmpLo = 3'd2;
    localparam logic [2:0] AddrMtimecmpHi = 3'd3;
    localparam logic [2:0] AddrMsip       = 3'd4;
    localparam logic [2:0] AddrExtClaim   = 3'd5;

    localparam int unsigned MipMsiBit = 3;
    localparam int unsigned MipMtiBit = 7;
    localparam int unsigned MipMeiBit = 11;

    localparam logic [4:0] CauseMsi = 5'd3;
    localparam logic [4:0] CauseMti = 5'd7;
    localparam logic [4:0] CauseMei = 5'd11;

    typedef enum logic {
        StIdle,
        StTaken
    } state_e;

    // Fixed priority MEI > MSI > MTI; only called when some source is pending.
    function automatic logic [4:0] cause_sel(input logic mei, input logic msi);
        if (mei) begin
            return CauseMei;
        end else if (msi) begin
            return CauseMsi;
        end
        return CauseMti;
    endfunction

endpackage

// File: rtl/clint_mtime.sv
// CLINT-style 64-bit free-running mtime with mtimecmp, half-word bus writes and
// the unsigned compare that produces MTIP.
module clint_mtime
    import int_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        mtip_o,
    output logic [31:0] rdata_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    // A write to either mtime half freezes the whole counter for that cycle.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (wr_en_i) begin
            case (addr_i)
                AddrMtimeLo:    mtime_d = {mtime_q[63:32], wdata_i};
                AddrMtimeHi:    mtime_d = {wdata_i, mtime_q[31:0]};
                AddrMtimecmpLo: mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
                AddrMtimecmpHi: mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
                default:        ;
            endcase
        end
    end

    always_comb begin
        case (addr_i)
            AddrMtimeLo:    rdata_o = mtime_q[31:0];
            AddrMtimeHi:    rdata_o = mtime_q[63:32];
            AddrMtimecmpLo: rdata_o = mtimecmp_q[31:0];
            AddrMtimecmpHi: rdata_o = mtimecmp_q[63:32];
            default:        rdata_o = '0;
        endcase
    end

    assign mtip_o = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/int_ctrl.sv
// Machine-level interrupt controller: timer, msip, external capture, mip image and
// take FSM. Define INT_CTRL_EXT_SYNC_EN to add a two-flop synchronizer on ext_irq.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_EXT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               bus_sel,
    input  logic               bus_we,
    input  logic [2:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic [31:0]        mie,
    input  logic               MIE,
    input  logic               stall,
    input  logic               mret,
    output logic [31:0]        mip_out,
    output logic               int_action,
    output logic [4:0]         int_code,
    output logic               hw_int,
    output logic               timer_irq
);

    logic               wr_en;
    logic               mtip;
    logic [31:0]        mtime_rdata;
    logic               msip_q, msip_d;
    logic [NUM_EXT-1:0] ext_cap_q;
    logic [31:0]        ext_claim;
    logic [31:0]        mip_q, mip_d;
    logic [31:0]        pend;
    logic               take_req;
    state_e             state_q, state_d;
    logic               int_action_q, int_action_d;
    logic [4:0]         int_code_q, int_code_d;
    logic               hw_int_q, hw_int_d;

    assign wr_en = bus_sel & bus_we;

    clint_mtime u_clint_mtime (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en_i (wr_en),
        .addr_i  (bus_addr),
        .wdata_i (bus_wdata),
        .mtip_o  (mtip),
        .rdata_o (mtime_rdata)
    );

    assign msip_d = (wr_en && bus_addr == AddrMsip) ? bus_wdata[0] : msip_q;

`ifdef INT_CTRL_EXT_SYNC_EN
    logic [NUM_EXT-1:0] ext_meta_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_meta_q <= '0;
            ext_cap_q  <= '0;
        end else begin
            ext_meta_q <= ext_irq;
            ext_cap_q  <= ext_meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_cap_q <= '0;
        end else begin
            ext_cap_q <= ext_irq;
        end
    end
`endif

    // Scan downwards so the lowest-index active line wins.
    always_comb begin
        ext_claim = '0;
        for (int i = int'(NUM_EXT) - 1; i >= 0; i--) begin
            if (ext_cap_q[i]) begin
                ext_claim = {1'b1, 27'b0, i[3:0]};
            end
        end
    end

    always_comb begin
        mip_d            = '0;
        mip_d[MipMsiBit] = msip_q;
        mip_d[MipMtiBit] = mtip;
        mip_d[MipMeiBit] = |ext_cap_q;
    end

    always_comb begin
        case (bus_addr)
            AddrMtimeLo, AddrMtimeHi,
            AddrMtimecmpLo, AddrMtimecmpHi: bus_rdata = mtime_rdata;
            AddrMsip:                       bus_rdata = {31'b0, msip_q};
            AddrExtClaim:                   bus_rdata = ext_claim;
            default:                        bus_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msip_q <= 1'b0;
            mip_q  <= '0;
        end else begin
            msip_q <= msip_d;
            mip_q  <= mip_d;
        end
    end

    // Decision uses registered mip only, so a same-cycle bus write is seen a cycle later.
    assign pend     = mip_q & mie;
    assign take_req = MIE && (|pend) && !stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            int_action_q <= 1'b0;
            int_code_q   <= '0;
            hw_int_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_action_q <= int_action_d;
            int_code_q   <= int_code_d;
            hw_int_q     <= hw_int_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take_req) state_d = StTaken;
            StTaken: if (mret) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        int_action_d = 1'b0;
        int_code_d   = int_code_q;
        hw_int_d     = hw_int_q;
        if (state_q == StIdle && take_req) begin
            int_action_d = 1'b1;
            int_code_d   = cause_sel(pend[MipMeiBit], pend[MipMsiBit]);
            hw_int_d     = 1'b1;
        end
    end

    assign mip_out    = mip_q;
    assign int_action = int_action_q;
    assign int_code   = int_code_q;
    assign hw_int     = hw_int_q;
    assign timer_irq  = mip_q[MipMtiBit];

endmodule

// File: tb/tb_int_ctrl.sv
// Randomized bench for int_ctrl against a cycle-level reference model of the
// interrupt rules, with a few directed scenarios up front.
module tb_int_ctrl;

    localparam int NUM_EXT = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               bus_sel = 1'b0;
    logic               bus_we = 1'b0;
    logic [2:0]         bus_addr = '0;
    logic [31:0]        bus_wdata = '0;
    logic [31:0]        bus_rdata;
    logic [NUM_EXT-1:0] ext_irq = '0;
    logic [31:0]        mie = '0;
    logic               mie_en = 1'b0;
    logic               stall = 1'b0;
    logic               mret = 1'b0;
    logic [31:0]        mip_out;
    logic               int_action;
    logic [4:0]         int_code;
    logic               hw_int;
    logic               timer_irq;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    // Reference model state
    logic [63:0]        m_mtime, m_cmp;
    logic               m_msip;
    logic [NUM_EXT-1:0] m_hist [2];
    logic [31:0]        m_mip;
    logic               m_taken, m_action, m_hw;
    logic [4:0]         m_code;

    int_ctrl #(.NUM_EXT(NUM_EXT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus_sel    (bus_sel),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .ext_irq    (ext_irq),
        .mie        (mie),
        .MIE        (mie_en),
        .stall      (stall),
        .mret       (mret),
        .mip_out    (mip_out),
        .int_action (int_action),
        .int_code   (int_code),
        .hw_int     (hw_int),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_EXT-1:0] m_cap();
`ifdef INT_CTRL_EXT_SYNC_EN
        return m_hist[1];
`else
        return m_hist[0];
`endif
    endfunction

    task automatic model_reset();
        m_mtime  = '0;
        m_cmp    = '1;
        m_msip   = 1'b0;
        m_hist[0] = '0;
        m_hist[1] = '0;
        m_mip    = '0;
        m_taken  = 1'b0;
        m_action = 1'b0;
        m_hw     = 1'b0;
        m_code   = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [NUM_EXT-1:0] cap;
        cap = m_cap();
        case (a)
            3'd0: return m_mtime[31:0];
            3'd1: return m_mtime[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {31'b0, m_msip};
            3'd5: begin
                for (int i = 0; i < NUM_EXT; i++) begin
                    if (cap[i]) return 32'h8000_0000 | 32'(i);
                end
                return 32'h0;
            end
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_clock();
        logic [31:0] mip_n, pend;
        mip_n     = '0;
        mip_n[3]  = m_msip;
        mip_n[7]  = (m_mtime >= m_cmp);
        mip_n[11] = |m_cap();
        pend      = m_mip & mie;
        m_action  = 1'b0;
        if (!m_taken) begin
            if (mie_en && pend != 0 && !stall) begin
                m_action = 1'b1;
                m_code   = pend[11] ? 5'd11 : (pend[3] ? 5'd3 : 5'd7);
                m_hw     = 1'b1;
                m_taken  = 1'b1;
            end
        end else if (mret) begin
            m_taken = 1'b0;
        end
        if (bus_sel && bus_we && bus_addr == 3'd0) begin
            m_mtime[31:0] = bus_wdata;
        end else if (bus_sel && bus_we && bus_addr == 3'd1) begin
            m_mtime[63:32] = bus_wdata;
        end else begin
            m_mtime = m_mtime + 64'd1;
        end
        if (bus_sel && bus_we) begin
            case (bus_addr)
                3'd2: m_cmp[31:0]  = bus_wdata;
                3'd3: m_cmp[63:32] = bus_wdata;
                3'd4: m_msip       = bus_wdata[0];
                default: ;
            endcase
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = ext_irq;
        m_mip     = mip_n;
    endtask

    task automatic check_outputs();
        check_val("mip_out", 64'(mip_out), 64'(m_mip));
        check_val("int_action", 64'(int_action), 64'(m_action));
        check_val("int_code", 64'(int_code), 64'(m_code));
        check_val("hw_int", 64'(hw_int), 64'(m_hw));
        check_val("timer_irq", 64'(timer_irq), 64'(m_mip[7]));
        if (int_action === 1'b1) pulses++;
    endtask

    // Inputs are already driven (just after a falling edge); run one full cycle.
    task automatic cycle();
        #1;
        check_val("bus_rdata", 64'(bus_rdata), 64'(m_read(bus_addr)));
        model_clock();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus_sel = 1'b0;
        bus_we  = 1'b0;
        mret    = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        cycle();
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic do_reset();
        idle_inputs();
        ext_irq = '0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_val("state_reset", 64'(dut.state_q), 64'(0));
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
    endtask

    task automatic rand_inputs();
        bus_sel  = ($urandom_range(0, 4) == 0);
        bus_we   = $urandom_range(0, 1) != 0;
        bus_addr = 3'($urandom_range(0, 7));
        case (bus_addr)
            3'd0:    bus_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            3'd1:    bus_wdata = 32'($urandom_range(0, 1));
            3'd2:    bus_wdata = m_mtime[31:0] + 32'($urandom_range(0, 60));
            3'd3:    bus_wdata = m_mtime[63:32] + 32'($urandom_range(0, 1));
            default: bus_wdata = $urandom;
        endcase
        if ($urandom_range(0, 9) == 0) ext_irq = NUM_EXT'($urandom);
        if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 5))
                0: mie = 32'h0;
                1: mie = 32'h8;
                2: mie = 32'h80;
                3: mie = 32'h800;
                4: mie = 32'h888;
                default: mie = $urandom;
            endcase
        end
        mie_en = ($urandom_range(0, 4) != 0);
        stall  = ($urandom_range(0, 3) == 0);
        mret   = ($urandom_range(0, 6) == 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // Timer interrupt at mtime == 20, then held in TAKEN, then mret.
        mie_en = 1'b1;
        mie    = 32'h80;
        bus_write(3'd3, 32'h0);
        bus_write(3'd2, 32'd20);
        pulses = 0;
        repeat (60) cycle();
        check_val("mti_pulse_count", 64'(pulses), 64'd1);
        check_val("mti_code", 64'(int_code), 64'd7);
        mret = 1'b1;
        cycle();
        mret = 1'b0;
        check_val("no_pulse_mret_cycle", 64'(int_action), 64'd0);
        cycle();
        check_val("pulse_after_mret", 64'(int_action), 64'd1);
        check_val("mti_pulse_count2", 64'(pulses), 64'd2);

        // Reset while TAKEN; no source enabled afterwards.
        do_reset();
        mie = 32'h0;
        pulses = 0;
        repeat (10) cycle();
        check_val("no_pulse_after_reset", 64'(pulses), 64'd0);

        // MSI and MEI together: MEI wins; claim reports line 2.
        mie    = 32'h888;
        mie_en = 1'b1;
        ext_irq = 4'b0100;
        bus_write(3'd4, 32'h1);
        bus_addr = 3'd5;
        repeat (6) cycle();
        check_val("claim_line2", 64'(bus_rdata), 64'h8000_0002);
        check_val("mei_wins", 64'(int_code), 64'd11);

        // mtime wrap with write-cycle increment suppressed.
        do_reset();
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_addr = 3'd1;
        cycle();
        check_val("mtime_hi_wrapped", 64'(bus_rdata), 64'd0);
        bus_addr = 3'd0;
        cycle();

        // Stall held with pending MSI.
        do_reset();
        mie    = 32'h8;
        mie_en = 1'b1;
        bus_write(3'd4, 32'h1);
        stall  = 1'b1;
        pulses = 0;
        repeat (5) cycle();
        check_val("stall_no_pulse", 64'(pulses), 64'd0);
        stall = 1'b0;
        cycle();
        check_val("pulse_after_stall", 64'(int_action), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rand_inputs();
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
